// File: rtl/pc_update_unit.sv
// pc_update_unit: program counter and EPC ownership for the multicycle CPU.
// Picks the next PC from the sequential, branch, jump, jr, rte and exception
// sources. A misaligned redirect target is trapped to the exception vector
// and the faulting PC is captured into EPC.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_00FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        zero,
    input  logic        neg,
    input  logic [2:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] reg_a,
    input  logic [25:0] jump_offset,
    input  logic        epc_write,
    input  logic [31:0] epc_in,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [31:0] jump_target,
    output logic        addr_exc
);

    typedef enum logic [1:0] {
        BR_BEQ  = 2'b00,
        BR_BNE  = 2'b01,
        BR_BLEZ = 2'b10,
        BR_BGTZ = 2'b11
    } br_e;

    typedef enum logic [2:0] {
        SRC_SEQ    = 3'b000,
        SRC_BRANCH = 3'b001,
        SRC_JUMP   = 3'b010,
        SRC_JR     = 3'b011,
        SRC_RTE    = 3'b100,
        SRC_EXC    = 3'b101
    } src_e;

    logic        cond;
    logic        we;
    logic [31:0] cand;
    logic        cand_valid;
    logic        cand_checked;
    logic        trap;

    // Jump target is built from the already-incremented registered PC.
    assign jump_target = {pc[31:28], jump_offset, 2'b00};

    // Branch condition decode from the ALU flags.
    always_comb begin
        cond = 1'b0;
        case (br_e'(branch_type))
            BR_BEQ:  cond = zero;
            BR_BNE:  cond = ~zero;
            BR_BLEZ: cond = zero | neg;
            BR_BGTZ: cond = ~zero & ~neg;
            default: cond = 1'b0;
        endcase
    end

    assign we = pc_write | (pc_write_cond & cond);

    // Next-PC candidate select; reserved codes produce no write at all.
    always_comb begin
        cand         = pc;
        cand_valid   = 1'b1;
        cand_checked = 1'b0;
        case (pc_source)
            SRC_SEQ:    cand = alu_result;
            SRC_BRANCH: begin cand = alu_out; cand_checked = 1'b1; end
            SRC_JUMP:   cand = jump_target;
            SRC_JR:     begin cand = reg_a;   cand_checked = 1'b1; end
            SRC_RTE:    begin cand = epc;     cand_checked = 1'b1; end
            SRC_EXC:    cand = EXC_VECTOR;
            default:    cand_valid = 1'b0;
        endcase
    end

    // Only register-sourced redirects can be misaligned.
    assign trap = we & cand_checked & (cand[1:0] != 2'b00);

    // PC / EPC / trap-pulse registers; trap capture beats an EPC load.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            epc      <= 32'h0;
            addr_exc <= 1'b0;
        end else begin
            addr_exc <= trap;
            if (trap) begin
                pc  <= EXC_VECTOR;
                epc <= pc;
            end else begin
                if (we && cand_valid)
                    pc <= cand;
                if (epc_write)
                    epc <= epc_in;
            end
        end
    end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed plus randomized check of pc_update_unit against a behavioural model.
module tb_pc_update_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_V  = 32'h0000_00FC;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write, pc_write_cond;
    logic [1:0]  branch_type;
    logic        zero, neg;
    logic [2:0]  pc_source;
    logic [31:0] alu_result, alu_out, reg_a;
    logic [25:0] jump_offset;
    logic        epc_write;
    logic [31:0] epc_in;
    logic [31:0] pc, epc, jump_target;
    logic        addr_exc;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [31:0] m_pc, m_epc;
    logic        m_exc;

    pc_update_unit #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_V)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .branch_type(branch_type), .zero(zero), .neg(neg), .pc_source(pc_source),
        .alu_result(alu_result), .alu_out(alu_out), .reg_a(reg_a),
        .jump_offset(jump_offset), .epc_write(epc_write), .epc_in(epc_in),
        .pc(pc), .epc(epc), .jump_target(jump_target), .addr_exc(addr_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock from the current inputs, straight from the rules.
    task automatic model_edge();
        logic        c, w, trap;
        logic [31:0] t;
        bit          ok, checked;
        logic [31:0] jt;
        jt = {m_pc[31:28], jump_offset, 2'b00};
        c = (branch_type == 2'd0) ? zero :
            (branch_type == 2'd1) ? !zero :
            (branch_type == 2'd2) ? (zero || neg) : (!zero && !neg);
        w = pc_write || (pc_write_cond && c);
        ok = (pc_source <= 3'd5);
        checked = (pc_source == 3'd1) || (pc_source == 3'd3) || (pc_source == 3'd4);
        case (pc_source)
            3'd0: t = alu_result;
            3'd1: t = alu_out;
            3'd2: t = jt;
            3'd3: t = reg_a;
            3'd4: t = m_epc;
            default: t = EXC_V;
        endcase
        trap = w && checked && (t % 4 != 0);
        if (reset) begin
            m_pc = RST_PC; m_epc = 0; m_exc = 0;
        end else if (trap) begin
            m_epc = m_pc; m_pc = EXC_V; m_exc = 1;
        end else begin
            m_exc = 0;
            if (w && ok) m_pc = t;
            if (epc_write) m_epc = epc_in;
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".epc"}, epc, m_epc);
        chk({tag, ".exc"}, {31'b0, addr_exc}, {31'b0, m_exc});
    endtask

    task automatic idle();
        reset = 0; pc_write = 0; pc_write_cond = 0; branch_type = 0; zero = 0; neg = 0;
        pc_source = 0; epc_write = 0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        idle();
        pc_write = 1; pc_source = 3'd0; alu_result = v;
        tick("setpc");
        pc_write = 0;
    endtask

    task automatic branch(input string tag, input logic [1:0] bt, input logic z, input logic n,
                          input logic [31:0] exp_pc);
        set_pc(32'h8);
        pc_write_cond = 1; pc_source = 3'd1; alu_out = 32'h100;
        branch_type = bt; zero = z; neg = n;
        tick(tag);
        chk({tag, ".const"}, pc, exp_pc);
        idle();
    endtask

    initial begin
        idle();
        alu_result = 0; alu_out = 0; reg_a = 0; jump_offset = 0; epc_in = 0;
        m_pc = 32'hx; m_epc = 32'hx; m_exc = 1'bx;

        // Reset held two cycles over an active write.
        reset = 1; pc_write = 1; alu_result = 32'h40;
        tick("rst0");
        tick("rst1");
        chk("rst.pc_const", pc, 32'h0);
        reset = 0;
        tick("rst_rel");
        chk("rst_rel.const", pc, 32'h40);

        // Jump target is combinational from registered pc.
        set_pc(32'hA000_0010);
        jump_offset = 26'h0000123; pc_source = 3'd2; pc_write = 1;
        #1;
        chk("jt.comb", jump_target, 32'hA000_048C);
        tick("jump");
        chk("jump.const", pc, 32'hA000_048C);
        idle();

        // Branch conditions.
        branch("beq_t",  2'd0, 1, 0, 32'h100);
        branch("beq_f",  2'd0, 0, 0, 32'h8);
        branch("bne_t",  2'd1, 0, 0, 32'h100);
        branch("bne_f",  2'd1, 1, 0, 32'h8);
        branch("blez_t", 2'd2, 0, 1, 32'h100);
        branch("blez_f", 2'd2, 0, 0, 32'h8);
        branch("bgtz_t", 2'd3, 0, 0, 32'h100);
        branch("bgtz_f", 2'd3, 0, 1, 32'h8);

        // Misaligned jr traps; trap beats the EPC load; pulse lasts one cycle.
        set_pc(32'h20);
        reg_a = 32'h1002; pc_source = 3'd3; pc_write = 1; epc_write = 1; epc_in = 32'h55;
        tick("jr_mis");
        chk("jr_mis.pc_const", pc, 32'hFC);
        chk("jr_mis.epc_const", epc, 32'h20);
        chk("jr_mis.exc_const", {31'b0, addr_exc}, 32'h1);
        idle();
        tick("jr_mis_after");
        chk("jr_mis_after.exc_const", {31'b0, addr_exc}, 32'h0);

        // rte and reserved codes.
        epc_write = 1; epc_in = 32'h84;
        tick("epc_load");
        idle();
        pc_source = 3'd4; pc_write = 1;
        tick("rte");
        chk("rte.const", pc, 32'h84);
        pc_source = 3'd6; alu_result = 32'h400;
        tick("rsv6");
        pc_source = 3'd7;
        tick("rsv7");
        chk("rsv.const", pc, 32'h84);
        idle();

        // Reset on the same edge as a trap condition.
        set_pc(32'h20);
        reg_a = 32'h1002; pc_source = 3'd3; pc_write = 1; reset = 1;
        tick("rst_trap");
        chk("rst_trap.const", pc, RST_PC);
        idle();

        // Wrap-around on the sequential path.
        set_pc(32'hFFFF_FFFC);
        pc_write = 1; alu_result = 32'h0;
        tick("wrap");
        idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 31) == 0);
            pc_write      = $urandom_range(0, 1);
            pc_write_cond = $urandom_range(0, 1);
            branch_type   = 2'($urandom);
            zero          = $urandom_range(0, 1);
            neg           = $urandom_range(0, 1);
            pc_source     = 3'($urandom);
            alu_result    = $urandom;
            alu_out       = $urandom;
            reg_a         = $urandom;
            jump_offset   = 26'($urandom);
            epc_write     = $urandom_range(0, 1);
            epc_in        = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                alu_out[1:0] = 2'b00; reg_a[1:0] = 2'b00; epc_in[1:0] = 2'b00;
            end
            tick("rand");
            #1;
            chk("rand.jt", jump_target, {m_pc[31:28], jump_offset, 2'b00});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
